// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if -- bundle between the control decoder side (master) and
// the instruction-address sequencer (slave).
//
// Signals:
//   flag_pc[1:0]  PC action: 0 hold/halt, 1 increment, 2 jump, 3 delay+increment
//   flag_jr       jump source select: 1 = reg_addr, 0 = jump_addr
//   led_in        IN instruction active
//   in_confirm    operator confirm pulse
//   jump_addr     immediate jump target
//   reg_addr      register jump target
//   irq_req       interrupt request (level)
//   irq_done      end-of-service pulse
//   pc            current instruction address
//   interruption  high while servicing an interrupt
//   saved_pc      return address captured at interrupt entry
//   delay_busy    high while in the delay state
//   in_wait       high while waiting for operator confirm
//   halted        high while halted
//   instr_count   retired-address-update counter (PC_SEQ_INSTR_COUNT_EN only)
//
// Handshake semantics: there is no valid/ready pair on this bundle. Every
// input is sampled on each rising clock edge. in_confirm and irq_done are
// one-cycle pulses that only take effect in the state that waits for them
// (WAIT_IN and IRQ respectively) and are ignored anywhere else. irq_req is a
// level that is honoured only in RUN or HALT and otherwise stays pending.
//
// Optional feature macro: PC_SEQ_INSTR_COUNT_EN adds instr_count.

interface pc_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic [1:0]        flag_pc;
  logic              flag_jr;
  logic              led_in;
  logic              in_confirm;
  logic [ADDR_W-1:0] jump_addr;
  logic [ADDR_W-1:0] reg_addr;
  logic              irq_req;
  logic              irq_done;

  logic [ADDR_W-1:0] pc;
  logic              interruption;
  logic [ADDR_W-1:0] saved_pc;
  logic              delay_busy;
  logic              in_wait;
  logic              halted;
`ifdef PC_SEQ_INSTR_COUNT_EN
  logic [31:0]       instr_count;
`endif

`ifdef PC_SEQ_INSTR_COUNT_EN
  modport master (
    output flag_pc, flag_jr, led_in, in_confirm, jump_addr, reg_addr,
           irq_req, irq_done,
    input  pc, interruption, saved_pc, delay_busy, in_wait, halted,
           instr_count
  );

  modport slave (
    input  flag_pc, flag_jr, led_in, in_confirm, jump_addr, reg_addr,
           irq_req, irq_done,
    output pc, interruption, saved_pc, delay_busy, in_wait, halted,
           instr_count
  );
`else
  modport master (
    output flag_pc, flag_jr, led_in, in_confirm, jump_addr, reg_addr,
           irq_req, irq_done,
    input  pc, interruption, saved_pc, delay_busy, in_wait, halted
  );

  modport slave (
    input  flag_pc, flag_jr, led_in, in_confirm, jump_addr, reg_addr,
           irq_req, irq_done,
    output pc, interruption, saved_pc, delay_busy, in_wait, halted
  );
`endif
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer -- instruction-address sequencer.
//
// Consumes the decoded control flags and drives the instruction-memory
// address. Owns all multi-cycle PC behaviour: the DELAY wait, the IN
// operator-confirm wait, HALT, and interrupt entry/return. interruption is
// fed back to the control decoder, which idles its flags while it is high.
//
// Ports:
//   clock      input   system clock, rising edge
//   reset      input   synchronous, active-high reset
//   bus        pc_sequencer_if.slave (flags, addresses, irq, pc and status)
//   state_dbg  output  current FSM state encoding (debug visibility)
//
// Parameters:
//   ADDR_W        width of pc, jump and saved addresses
//   DELAY_CYCLES  cycles spent in DELAY (0 behaves as 1)
//   CNT_W         delay counter width; must hold DELAY_CYCLES
//
// Optional feature macro: PC_SEQ_INSTR_COUNT_EN adds bus.instr_count, a
// 32-bit count of pc updates from RUN, DELAY completion and WAIT_IN confirm.
//
// All outputs are registers; nothing on the bus flows combinationally from
// an input to an output.

module pc_sequencer #(
  parameter int ADDR_W       = 8,
  parameter int DELAY_CYCLES = 50000000,
  parameter int CNT_W        = 32
) (
  input  logic         clock,
  input  logic         reset,
  pc_sequencer_if.slave bus,
  output logic [2:0]   state_dbg
);

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_DELAY   = 3'd1,
    ST_WAIT_IN = 3'd2,
    ST_HALT    = 3'd3,
    ST_IRQ     = 3'd4
  } state_t;

  // Counter load value: the counter counts down to zero inclusive, so the
  // DELAY state lasts DELAY_LOAD+1 cycles. A zero delay is treated as one.
  localparam logic [CNT_W-1:0] DELAY_LOAD =
    (DELAY_CYCLES <= 1) ? '0 : CNT_W'(DELAY_CYCLES - 1);

  localparam logic [1:0] PC_HOLD  = 2'd0;
  localparam logic [1:0] PC_INC   = 2'd1;
  localparam logic [1:0] PC_JUMP  = 2'd2;
  localparam logic [1:0] PC_DELAY = 2'd3;

  state_t            state_q, state_n;
  logic [ADDR_W-1:0] pc_q, pc_n;
  logic [ADDR_W-1:0] saved_q, saved_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic              adv;

  logic              delay_busy_q;
  logic              in_wait_q;
  logic              halted_q;
  logic              interruption_q;

  logic [ADDR_W-1:0] pc_inc;
  assign pc_inc = pc_q + ADDR_W'(1);  // wraps modulo 2^ADDR_W

  // Next-state / next-pc decision. adv marks an edge that counts as an
  // instruction-address update (not the IRQ return).
  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    saved_n = saved_q;
    cnt_n   = cnt_q;
    adv     = 1'b0;

    case (state_q)
      ST_RUN: begin
        case (bus.flag_pc)
          PC_HOLD: begin
            state_n = ST_HALT;
          end
          PC_INC: begin
            if (bus.led_in) begin
              state_n = ST_WAIT_IN;
            end else begin
              pc_n = pc_inc;
              adv  = 1'b1;
            end
          end
          PC_JUMP: begin
            pc_n = bus.flag_jr ? bus.reg_addr : bus.jump_addr;
            adv  = 1'b1;
          end
          PC_DELAY: begin
            cnt_n   = DELAY_LOAD;
            state_n = ST_DELAY;
          end
          default: ;
        endcase
        // The flag-driven pc update of this edge still happens; the
        // interrupt then returns to the address it produced.
        if (bus.irq_req) begin
          saved_n = pc_n;
          state_n = ST_IRQ;
        end
      end

      ST_DELAY: begin
        if (cnt_q == '0) begin
          pc_n    = pc_inc;
          adv     = 1'b1;
          state_n = ST_RUN;
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end

      ST_WAIT_IN: begin
        if (bus.in_confirm) begin
          pc_n    = pc_inc;
          adv     = 1'b1;
          state_n = ST_RUN;
        end
      end

      ST_HALT: begin
        if (bus.irq_req) begin
          saved_n = pc_q;
          state_n = ST_IRQ;
        end
      end

      ST_IRQ: begin
        // Always resume in RUN, even when the interrupt was taken from HALT.
        if (bus.irq_done) begin
          pc_n    = saved_q;
          state_n = ST_RUN;
        end
      end

      default: begin
        state_n = ST_RUN;
      end
    endcase
  end

  // State, datapath and registered one-hot status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_RUN;
      pc_q           <= '0;
      saved_q        <= '0;
      cnt_q          <= '0;
      delay_busy_q   <= 1'b0;
      in_wait_q      <= 1'b0;
      halted_q       <= 1'b0;
      interruption_q <= 1'b0;
    end else begin
      state_q        <= state_n;
      pc_q           <= pc_n;
      saved_q        <= saved_n;
      cnt_q          <= cnt_n;
      delay_busy_q   <= (state_n == ST_DELAY);
      in_wait_q      <= (state_n == ST_WAIT_IN);
      halted_q       <= (state_n == ST_HALT);
      interruption_q <= (state_n == ST_IRQ);
    end
  end

`ifdef PC_SEQ_INSTR_COUNT_EN
  logic [31:0] instr_count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      instr_count_q <= '0;
    end else if (adv) begin
      instr_count_q <= instr_count_q + 32'd1;
    end
  end

  assign bus.instr_count = instr_count_q;
`else
  // adv only feeds the optional counter; keep it visibly consumed.
  logic adv_unused;
  assign adv_unused = adv;
`endif

  assign bus.pc           = pc_q;
  assign bus.saved_pc     = saved_q;
  assign bus.delay_busy   = delay_busy_q;
  assign bus.in_wait      = in_wait_q;
  assign bus.halted       = halted_q;
  assign bus.interruption = interruption_q;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer -- directed bench for pc_sequencer with ADDR_W=8 and
// DELAY_CYCLES=4. Inputs are driven and outputs sampled 1 time unit after
// each rising edge.

module tb_pc_sequencer;

  localparam int ADDR_W = 8;

  logic       clock;
  logic       reset;
  logic [2:0] state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  pc_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  pc_sequencer #(
    .ADDR_W       (ADDR_W),
    .DELAY_CYCLES (4),
    .CNT_W        (32)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] fpc, input logic jr, input logic led,
                       input logic [7:0] jaddr, input logic [7:0] raddr);
    bus.flag_pc   = fpc;
    bus.flag_jr   = jr;
    bus.led_in    = led;
    bus.jump_addr = jaddr;
    bus.reg_addr  = raddr;
  endtask

  // checker
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic db, input logic iw,
                              input logic h, input logic irq);
    check({tag, ".delay_busy"},   32'(bus.delay_busy),   32'(db));
    check({tag, ".in_wait"},      32'(bus.in_wait),      32'(iw));
    check({tag, ".halted"},       32'(bus.halted),       32'(h));
    check({tag, ".interruption"}, 32'(bus.interruption), 32'(irq));
  endtask

  initial begin
    reset          = 1'b1;
    bus.in_confirm = 1'b0;
    bus.irq_req    = 1'b0;
    bus.irq_done   = 1'b0;
    drive(2'd1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();

    // reset state
    check("rst.pc", 32'(bus.pc), 32'h0);
    check("rst.saved_pc", 32'(bus.saved_pc), 32'h0);
    check_status("rst", 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef PC_SEQ_INSTR_COUNT_EN
    check("rst.instr_count", bus.instr_count, 32'd0);
`endif

    // increment x3
    reset = 1'b0;
    tick(); check("inc1.pc", 32'(bus.pc), 32'h1);
    tick(); check("inc2.pc", 32'(bus.pc), 32'h2);
    tick(); check("inc3.pc", 32'(bus.pc), 32'h3);
    check_status("inc3", 1'b0, 1'b0, 1'b0, 1'b0);

    // jump to FF, then wrap, then register jump
    drive(2'd2, 1'b0, 1'b0, 8'hFF, 8'h00);
    tick(); check("jmp_ff.pc", 32'(bus.pc), 32'hFF);
`ifdef PC_SEQ_INSTR_COUNT_EN
    check("cnt_after_jump", bus.instr_count, 32'd4);
`endif
    drive(2'd1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick(); check("wrap.pc", 32'(bus.pc), 32'h00);
    drive(2'd2, 1'b1, 1'b0, 8'h10, 8'h40);
    tick(); check("jr.pc", 32'(bus.pc), 32'h40);

    // delay with irq raised mid-delay
    drive(2'd2, 1'b0, 1'b0, 8'h05, 8'h40);
    tick(); check("jmp5.pc", 32'(bus.pc), 32'h05);
    drive(2'd3, 1'b0, 1'b0, 8'h05, 8'h40);
    tick();
    drive(2'd1, 1'b0, 1'b0, 8'h05, 8'h40);
    bus.irq_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("delay%0d.pc", i), 32'(bus.pc), 32'h05);
      check_status($sformatf("delay%0d", i), 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    check("delay_done.pc", 32'(bus.pc), 32'h06);
    check_status("delay_done", 1'b0, 1'b0, 1'b0, 1'b0);
    // deferred irq taken from RUN along with the increment
    tick();
    check("irq_defer.pc", 32'(bus.pc), 32'h07);
    check("irq_defer.saved_pc", 32'(bus.saved_pc), 32'h07);
    check_status("irq_defer", 1'b0, 1'b0, 1'b0, 1'b1);
    bus.irq_req  = 1'b0;
    bus.irq_done = 1'b1;
    drive(2'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    bus.irq_done = 1'b0;
    check("irq_ret1.pc", 32'(bus.pc), 32'h07);
    check_status("irq_ret1", 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef PC_SEQ_INSTR_COUNT_EN
    check("cnt_after_irq", bus.instr_count, 32'd9);
`endif

    // IN wait
    drive(2'd1, 1'b0, 1'b1, 8'h00, 8'h00);
    tick();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("wait%0d.pc", i), 32'(bus.pc), 32'h07);
      check($sformatf("wait%0d.in_wait", i), 32'(bus.in_wait), 32'h1);
      tick();
    end
    bus.in_confirm = 1'b1;
    tick();
    bus.in_confirm = 1'b0;
    check("confirm.pc", 32'(bus.pc), 32'h08);
    check_status("confirm", 1'b0, 1'b0, 1'b0, 1'b0);

    // irq from RUN with increment
    drive(2'd2, 1'b0, 1'b0, 8'h03, 8'h00);
    tick(); check("jmp3.pc", 32'(bus.pc), 32'h03);
    drive(2'd1, 1'b0, 1'b0, 8'h03, 8'h00);
    bus.irq_req = 1'b1;
    tick();
    bus.irq_req = 1'b0;
    check("irq.pc", 32'(bus.pc), 32'h04);
    check("irq.saved_pc", 32'(bus.saved_pc), 32'h04);
    check_status("irq", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("irq_hold.pc", 32'(bus.pc), 32'h04);
    check("irq_hold.interruption", 32'(bus.interruption), 32'h1);
    bus.irq_done = 1'b1;
    drive(2'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    bus.irq_done = 1'b0;
    check("irq_ret2.pc", 32'(bus.pc), 32'h04);
    check("irq_ret2.interruption", 32'(bus.interruption), 32'h0);

    // halt; stray in_confirm and flags ignored
    bus.in_confirm = 1'b1;
    tick();
    bus.in_confirm = 1'b0;
    check("halt.pc", 32'(bus.pc), 32'h04);
    check_status("halt", 1'b0, 1'b0, 1'b1, 1'b0);
    drive(2'd1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick(); tick(); tick();
    check("halt_hold.pc", 32'(bus.pc), 32'h04);
    check("halt_hold.halted", 32'(bus.halted), 32'h1);

    // irq from HALT returns to RUN
    bus.irq_req = 1'b1;
    tick();
    bus.irq_req = 1'b0;
    check("halt_irq.saved_pc", 32'(bus.saved_pc), 32'h04);
    check_status("halt_irq", 1'b0, 1'b0, 1'b0, 1'b1);
    drive(2'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    bus.irq_done = 1'b1;
    tick();
    bus.irq_done = 1'b0;
    check("halt_ret.pc", 32'(bus.pc), 32'h04);
    check_status("halt_ret", 1'b0, 1'b0, 1'b0, 1'b0);

    // halt again, then reset while halted
    tick();
    check("halt2.halted", 32'(bus.halted), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_halt.pc", 32'(bus.pc), 32'h0);
    check_status("rst_halt", 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef PC_SEQ_INSTR_COUNT_EN
    check("rst_halt.instr_count", bus.instr_count, 32'd0);
`endif

    // reset mid-DELAY
    drive(2'd3, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    check("delay2.delay_busy", 32'(bus.delay_busy), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(2'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    check("rst_delay.pc", 32'(bus.pc), 32'h0);
    check_status("rst_delay", 1'b0, 1'b0, 1'b0, 1'b0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
